ddr_local_responder: RTL and testbench

- Responder end of the arbiter's internal SDRAM-side interface: accepts the selected port's access (`acc_i`, `we_i`, `adr_i`, `dat_i`, `sel_i`, `buf_width_i`) and returns `ack_o`, `dat_o`, `adr_o` and `idle_o`.
- Translates each access into Altera DDR controller local-interface (Avalon-MM style) transactions.
- Writes are single-word. Reads are aligned bursts of 2^`buf_width_i` words that refill a port buffer.
- Sits between the port arbiter and the DDR controller, entirely in the `sdram_clk` domain.

---
 rtl/ddr_local_responder.sv | 195 +++++++++++++++++++
 tb/tb_ddr_local_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_local_responder.sv
// Responder between the port arbiter and the Altera DDR controller local interface.
// Single-word writes and aligned read bursts of 2^buf_width words, all outputs registered.
module ddr_local_responder #(
    parameter int LADR_WIDTH    = 24,
    parameter int MAX_BUF_WIDTH = 4,
    parameter int SIZE_WIDTH    = 5
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,
    input  logic                  acc_i,
    input  logic                  we_i,
    input  logic [31:0]           adr_i,
    input  logic [31:0]           dat_i,
    input  logic [3:0]            sel_i,
    input  logic [3:0]            buf_width_i,
    output logic                  ack_o,
    output logic [31:0]           adr_o,
    output logic [31:0]           dat_o,
    output logic                  idle_o,
    input  logic                  local_init_done,
    input  logic                  local_ready,
    output logic [LADR_WIDTH-1:0] local_address,
    output logic                  local_write_req,
    output logic                  local_read_req,
    output logic                  local_burstbegin,
    output logic [SIZE_WIDTH-1:0] local_size,
    output logic [31:0]           local_wdata,
    output logic [3:0]            local_be,
    input  logic [31:0]           local_rdata,
    input  logic                  local_rdata_valid
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_DATA,
        GUARD
    } state_t;

    function automatic logic [3:0] clamp_width(input logic [3:0] bw);
        return (bw > 4'(MAX_BUF_WIDTH)) ? 4'(MAX_BUF_WIDTH) : bw;
    endfunction

    function automatic logic [31:0] align_base(input logic [31:0] adr, input logic [3:0] bw);
        logic [31:0] span;
        span = 32'd4 << bw;
        return adr & ~(span - 32'd1);
    endfunction

    state_t                state_q, state_d;
    // Write: captured byte address. Read: aligned byte base of the burst.
    logic [31:0]           base_q, base_d;
    logic [SIZE_WIDTH-1:0] last_q, last_d;
    logic [SIZE_WIDTH-1:0] cnt_q, cnt_d;

    logic                  ack_d, idle_d, wr_d, rd_d, bb_d;
    logic [31:0]           adr_d, dat_d, wdata_d;
    logic [LADR_WIDTH-1:0] addr_d;
    logic [SIZE_WIDTH-1:0] size_d;
    logic [3:0]            be_d;

    logic [3:0]            bw_c;
    logic [31:0]           rd_base_c;
    logic [SIZE_WIDTH-1:0] rd_size_c;

    assign bw_c      = clamp_width(buf_width_i);
    assign rd_base_c = align_base(adr_i, bw_c);
    assign rd_size_c = SIZE_WIDTH'(1) << bw_c;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        adr_d   = adr_o;
        dat_d   = dat_o;
        idle_d  = idle_o;
        wr_d    = local_write_req;
        rd_d    = local_read_req;
        bb_d    = local_burstbegin;
        addr_d  = local_address;
        size_d  = local_size;
        wdata_d = local_wdata;
        be_d    = local_be;

        unique case (state_q)
            INIT: begin
                if (local_init_done) begin
                    state_d = IDLE;
                    idle_d  = 1'b1;
                end
            end
            IDLE: begin
                idle_d = 1'b1;
                if (acc_i) begin
                    idle_d = 1'b0;
                    bb_d   = 1'b1;
                    if (we_i) begin
                        state_d = WR_REQ;
                        base_d  = adr_i;
                        wr_d    = 1'b1;
                        addr_d  = adr_i[LADR_WIDTH+1:2];
                        size_d  = SIZE_WIDTH'(1);
                        wdata_d = dat_i;
                        be_d    = sel_i;
                    end else begin
                        state_d = RD_REQ;
                        base_d  = rd_base_c;
                        rd_d    = 1'b1;
                        addr_d  = rd_base_c[LADR_WIDTH+1:2];
                        size_d  = rd_size_c;
                        last_d  = rd_size_c - SIZE_WIDTH'(1);
                        cnt_d   = '0;
                    end
                end
            end
            WR_REQ: begin
                if (local_ready) begin
                    wr_d    = 1'b0;
                    bb_d    = 1'b0;
                    ack_d   = 1'b1;
                    adr_d   = base_q;
                    state_d = GUARD;
                end
            end
            RD_REQ: begin
                if (local_ready) begin
                    rd_d    = 1'b0;
                    bb_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (local_rdata_valid) begin
                    ack_d = 1'b1;
                    dat_d = local_rdata;
                    adr_d = base_q + (32'(cnt_q) << 2);
                    cnt_d = cnt_q + SIZE_WIDTH'(1);
                    if (cnt_q == last_q) begin
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                // Lets the port drop acc_i after its last ack before IDLE samples it again.
                state_d = IDLE;
                idle_d  = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q          <= INIT;
            base_q           <= '0;
            last_q           <= '0;
            cnt_q            <= '0;
            ack_o            <= 1'b0;
            adr_o            <= '0;
            dat_o            <= '0;
            idle_o           <= 1'b0;
            local_write_req  <= 1'b0;
            local_read_req   <= 1'b0;
            local_burstbegin <= 1'b0;
            local_address    <= '0;
            local_size       <= '0;
            local_wdata      <= '0;
            local_be         <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            last_q           <= last_d;
            cnt_q            <= cnt_d;
            ack_o            <= ack_d;
            adr_o            <= adr_d;
            dat_o            <= dat_d;
            idle_o           <= idle_d;
            local_write_req  <= wr_d;
            local_read_req   <= rd_d;
            local_burstbegin <= bb_d;
            local_address    <= addr_d;
            local_size       <= size_d;
            local_wdata      <= wdata_d;
            local_be         <= be_d;
        end
    end

endmodule

// File: tb/tb_ddr_local_responder.sv
// Scoreboard bench for ddr_local_responder with a behavioural DDR controller and memory model.
module tb_ddr_local_responder;

    localparam int LW  = 24;
    localparam int MBW = 4;
    localparam int SW  = 5;

    logic          sdram_clk = 1'b0;
    logic          sdram_rst_n = 1'b0;
    logic          acc_i = 1'b0, we_i = 1'b0;
    logic [31:0]   adr_i = '0, dat_i = '0;
    logic [3:0]    sel_i = '0, buf_width_i = '0;
    logic          ack_o, idle_o;
    logic [31:0]   adr_o, dat_o;
    logic          local_init_done = 1'b0, local_ready = 1'b0;
    logic [LW-1:0] local_address;
    logic          local_write_req, local_read_req, local_burstbegin;
    logic [SW-1:0] local_size;
    logic [31:0]   local_wdata;
    logic [3:0]    local_be;
    logic [31:0]   local_rdata = '0;
    logic          local_rdata_valid = 1'b0;

    always #5 sdram_clk = ~sdram_clk;

    ddr_local_responder #(.LADR_WIDTH(LW), .MAX_BUF_WIDTH(MBW), .SIZE_WIDTH(SW)) dut (
        .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
        .acc_i(acc_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
        .buf_width_i(buf_width_i), .ack_o(ack_o), .adr_o(adr_o), .dat_o(dat_o), .idle_o(idle_o),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_address(local_address), .local_write_req(local_write_req),
        .local_read_req(local_read_req), .local_burstbegin(local_burstbegin),
        .local_size(local_size), .local_wdata(local_wdata), .local_be(local_be),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid)
    );

    typedef struct {
        bit            we;
        logic [LW-1:0] addr;
        logic [SW-1:0] size;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } req_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          rd;
        bit          last;
    } ack_t;

    req_t          exp_req[$];
    ack_t          exp_ack[$];
    logic [LW-1:0] beats[$];

    int          n_cmp = 0, n_bad = 0;
    int          ack_cnt = 0, req_len = 0, last_req_len = 0;
    bit          rand_ready = 0, beat_en = 1, hold_chk = 0, post_last = 0;
    int          gap_mode = 0, gap_idx = 0, low_left = 0;
    logic [31:0] m_adr = '0, m_dat = '0;
    bit          pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [LW-1:0] wa);
        return ({8'h00, wa} * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Request / ack monitor, sampled on the falling edge.
    always @(negedge sdram_clk) begin
        req_t r;
        ack_t a;
        if (sdram_rst_n) begin
            if (post_last) begin
                check("idle_after_guard", 64'(idle_o), 64'(1));
                post_last = 0;
            end
            if (local_write_req || local_read_req) req_len++;
            if ((local_write_req || local_read_req) && local_ready) begin
                last_req_len = req_len;
                req_len = 0;
                if (exp_req.size() == 0) begin
                    bound_fail("unexpected_request");
                end else begin
                    r = exp_req.pop_front();
                    check("req_kind", 64'({local_write_req, local_read_req, local_burstbegin}),
                          r.we ? 64'(3'b101) : 64'(3'b011));
                    check("req_addr", 64'(local_address), 64'(r.addr));
                    check("req_size", 64'(local_size), 64'(r.size));
                    if (r.we) begin
                        check("req_wdata", 64'(local_wdata), 64'(r.wdata));
                        check("req_be", 64'(local_be), 64'(r.be));
                    end else begin
                        for (int i = 0; i < int'(local_size); i++) beats.push_back(local_address + LW'(i));
                    end
                end
            end
            if (ack_o) begin
                ack_cnt++;
                if (exp_ack.size() == 0) begin
                    bound_fail("unexpected_ack");
                end else begin
                    a = exp_ack.pop_front();
                    check("ack_adr", 64'(adr_o), 64'(a.adr));
                    if (a.rd) check("ack_dat", 64'(dat_o), 64'(a.dat));
                    m_adr = a.adr;
                    if (a.rd) m_dat = a.dat;
                    hold_chk = a.rd && !a.last;
                    if (a.last) begin
                        check("guard_idle", 64'(idle_o), 64'(0));
                        post_last = 1;
                    end
                end
            end else if (hold_chk) begin
                check("hold_adr", 64'(adr_o), 64'(m_adr));
                check("hold_dat", 64'(dat_o), 64'(m_dat));
            end
        end
    end

    // Controller model: ready handshake and read beats with optional gaps.
    always @(posedge sdram_clk) begin
        bit give;
        #1;
        if (low_left > 0 && (local_write_req || local_read_req)) begin
            local_ready = 1'b0;
            low_left--;
        end else begin
            local_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (gap_mode == 0) give = 1;
        else if (gap_mode == 1) give = pat[gap_idx % 5];
        else give = 1'($urandom);
        if (beats.size() > 0) begin
            if (gap_mode == 1) gap_idx++;
            if (beat_en && give) begin
                local_rdata_valid = 1'b1;
                local_rdata = mem_word(beats.pop_front());
            end else begin
                local_rdata_valid = 1'b0;
                local_rdata = $urandom;
            end
        end else begin
            // Stray beats while no burst is outstanding must be ignored.
            local_rdata_valid = ($urandom_range(0, 3) == 0);
            local_rdata = $urandom;
        end
    end

    task automatic expect_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [3:0] bw, output int n);
        req_t        r;
        ack_t        a;
        int          bwc;
        logic [31:0] base;
        bwc = (int'(bw) > MBW) ? MBW : int'(bw);
        if (we) begin
            n = 1;
            r.we = 1; r.addr = LW'(adr / 4); r.size = SW'(1); r.wdata = dat; r.be = sel;
            exp_req.push_back(r);
            a.adr = adr; a.dat = '0; a.rd = 0; a.last = 1;
            exp_ack.push_back(a);
        end else begin
            n = 1 << bwc;
            base = adr - (adr % (32'(n) * 32'd4));
            r.we = 0; r.addr = LW'(base / 4); r.size = SW'(n); r.wdata = '0; r.be = '0;
            exp_req.push_back(r);
            for (int i = 0; i < n; i++) begin
                a.adr = base + 32'(4 * i);
                a.dat = mem_word(LW'(base / 4 + 32'(i)));
                a.rd = 1;
                a.last = (i == n - 1);
                exp_ack.push_back(a);
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (idle_o !== 1'b1 && t < 300) begin
            @(posedge sdram_clk); #1;
            t++;
        end
        if (idle_o !== 1'b1) bound_fail("wait_idle");
    endtask

    task automatic wait_acks(input int target, input bit scramble);
        int t = 0;
        while (ack_cnt < target && t < 400) begin
            if (scramble) begin
                we_i = 1'($urandom); adr_i = $urandom; dat_i = $urandom;
                sel_i = 4'($urandom); buf_width_i = 4'($urandom); acc_i = 1'($urandom);
            end
            @(posedge sdram_clk); #1;
            t++;
        end
        check("ack_count", 64'(ack_cnt), 64'(target));
    endtask

    task automatic do_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [3:0] bw, input bit scramble);
        int n, target;
        wait_idle();
        expect_access(we, adr, dat, sel, bw, n);
        target = ack_cnt + n;
        acc_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel; buf_width_i = bw;
        @(posedge sdram_clk); #1;
        check("idle_drop", 64'(idle_o), 64'(0));
        wait_acks(target, scramble);
        acc_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({ack_o, idle_o, local_write_req, local_read_req, local_burstbegin, local_size}), 64'(0));
        check({tag, "_resp"}, 64'({adr_o, dat_o}), 64'(0));
        check({tag, "_local"}, 64'({local_address, local_wdata, local_be}), 64'(0));
    endtask

    initial begin
        int n, target, saved;
        repeat (3) @(posedge sdram_clk);
        #1;
        check_zero("reset");
        sdram_rst_n = 1'b1;

        // Calibration not done: access must stall with idle_o low.
        acc_i = 1'b1; we_i = 1'b1; adr_i = 32'h0000_1234; dat_i = 32'hDEADBEEF; sel_i = 4'h3;
        buf_width_i = 4'h0;
        low_left = 3;
        repeat (10) begin
            @(posedge sdram_clk); #1;
            check("init_idle", 64'(idle_o), 64'(0));
            check("init_noreq", 64'(local_write_req | local_read_req), 64'(0));
        end
        local_init_done = 1'b1;
        expect_access(1'b1, 32'h0000_1234, 32'hDEADBEEF, 4'h3, 4'h0, n);
        target = ack_cnt + n;
        @(posedge sdram_clk); #1;
        check("init_to_idle", 64'(idle_o), 64'(1));
        @(posedge sdram_clk); #1;
        check("idle_drop", 64'(idle_o), 64'(0));
        wait_acks(target, 1'b0);
        acc_i = 1'b0;
        check("wr_req_len", 64'(last_req_len), 64'(4));

        // Directed reads: gapped beats, clamp, single word, address wrap.
        gap_mode = 1;
        do_access(1'b0, 32'h0000_0114, '0, '0, 4'd3, 1'b0);
        do_access(1'b0, 32'h0000_0A44, '0, '0, 4'd7, 1'b0);
        do_access(1'b0, 32'h0000_0A44, '0, '0, 4'd0, 1'b0);
        gap_mode = 0;
        do_access(1'b0, 32'hFFFF_FFF4, '0, '0, 4'd2, 1'b1);
        local_init_done = 1'b0;
        do_access(1'b1, 32'hFFFF_FFFC, 32'h1357_9BDF, 4'hC, 4'd0, 1'b1);
        local_init_done = 1'b1;

        // Reset in the middle of an 8-beat burst.
        gap_mode = 1;
        wait_idle();
        expect_access(1'b0, 32'h0000_2000, '0, '0, 4'd3, n);
        target = ack_cnt + 3;
        acc_i = 1'b1; we_i = 1'b0; adr_i = 32'h0000_2000; buf_width_i = 4'd3;
        begin
            int t = 0;
            while (ack_cnt < target && t < 100) begin
                @(posedge sdram_clk); #1;
                t++;
            end
            if (ack_cnt < target) bound_fail("reset_burst_wait");
        end
        #2;
        beat_en = 0;
        acc_i = 1'b0;
        sdram_rst_n = 1'b0;
        #1;
        check_zero("midrst");
        exp_ack.delete();
        exp_req.delete();
        hold_chk = 0;
        post_last = 0;
        req_len = 0;
        @(posedge sdram_clk); #1;
        sdram_rst_n = 1'b1;
        repeat (2) @(posedge sdram_clk);
        #1;
        check("reinit_idle", 64'(idle_o), 64'(1));
        saved = ack_cnt;
        beat_en = 1;
        repeat (15) @(posedge sdram_clk);
        #1;
        check("no_late_ack", 64'(ack_cnt), 64'(saved));
        check("late_beats_drained", 64'(beats.size()), 64'(0));

        // Randomized traffic.
        rand_ready = 1;
        gap_mode = 2;
        for (int k = 0; k < 40; k++) begin
            do_access(1'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom_range(0, 7)),
                      1'($urandom));
        end
        repeat (5) @(posedge sdram_clk);
        #1;
        check("exp_req_empty", 64'(exp_req.size()), 64'(0));
        check("exp_ack_empty", 64'(exp_ack.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
